// File: rtl/leiwand_rv32_wb_ram.sv
// Pipelined Wishbone-style RAM slave: one request per cycle, byte-lane writes,
// optional zero-clear after reset, error response for misaligned or out-of-range accesses.
module leiwand_rv32_wb_ram #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    MEM_SIZE       = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    CLEAR_ON_RESET = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cyc,
  input  logic                  i_stb,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_dat,
  input  logic [3:0]            i_dat_wr_size,
  output logic [DATA_WIDTH-1:0] o_dat,
  output logic                  o_ack,
  output logic                  o_err,
  output logic                  o_stall,
  output logic                  o_init_done
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam int IW = $clog2(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_SIZE * NB);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [DATA_WIDTH-1:0] mem_r [MEM_SIZE];
  logic [0:0]            state_r;
  logic [IW-1:0]         clr_idx_r;

  logic [ADDR_WIDTH-1:0] off_s;
  logic [IW-1:0]         idx_s;
  logic [LB-1:0]         lane_s;
  logic                  range_err_s;
  logic                  size_ok_s;
  logic                  align_err_s;
  logic                  err_s;
  logic                  acc_s;
  logic                  wr_s;
  logic                  clr_we_s;
  logic [NB-1:0]         be_s;
  logic [DATA_WIDTH-1:0] wdat_s;
  logic [DATA_WIDTH-1:0] rd_dat_s;

  logic                  s1_vld_r;
  logic                  s1_err_r;
  logic [DATA_WIDTH-1:0] s1_dat_r;
  logic                  rsp_vld_s;
  logic                  rsp_err_s;
  logic [DATA_WIDTH-1:0] rsp_dat_s;

  // Addresses below BASE_ADDR wrap to a huge offset and fall into the range error.
  assign off_s       = i_addr - BASE_ADDR;
  assign idx_s       = off_s[LB +: IW];
  assign lane_s      = off_s[LB-1:0];
  assign range_err_s = ({1'b0, off_s} >= MEM_BYTES);
  assign align_err_s = |(4'(lane_s) & (i_dat_wr_size - 4'd1));
  assign err_s       = range_err_s | ~size_ok_s | align_err_s;
  assign acc_s       = i_cyc & i_stb & ~o_stall;
  assign wr_s        = acc_s & i_we & ~err_s;
  assign clr_we_s    = (state_r == ST_INIT) && (CLEAR_ON_RESET != 0) && !i_rst;
  assign wdat_s      = i_dat << {lane_s, 3'b000};
  assign rd_dat_s    = (!i_we && !err_s) ? mem_r[idx_s] : '0;

  always_comb begin
    size_ok_s = 1'b0;
    be_s      = '0;
    case (i_dat_wr_size)
      4'd1, 4'd2, 4'd4: size_ok_s = 1'b1;
      4'd8:             size_ok_s = (NB == 8);
      default:          size_ok_s = 1'b0;
    endcase
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(lane_s)) && (b < int'(lane_s) + int'(i_dat_wr_size))) begin
        be_s[b] = 1'b1;
      end else begin
        be_s[b] = 1'b0;
      end
    end
  end

  // Init sequencer: optional one-word-per-cycle clear, then RUN.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_INIT;
      clr_idx_r   <= '0;
      o_stall     <= 1'b1;
      o_init_done <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          if ((CLEAR_ON_RESET == 0) || (clr_idx_r == IW'(MEM_SIZE - 1))) begin
            state_r     <= ST_RUN;
            o_stall     <= 1'b0;
            o_init_done <= 1'b1;
          end else begin
            clr_idx_r <= clr_idx_r + IW'(1);
          end
        end
        ST_RUN: begin
          o_stall     <= 1'b0;
          o_init_done <= 1'b1;
        end
        default: begin
          state_r     <= ST_INIT;
          o_stall     <= 1'b1;
          o_init_done <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset so contents survive a reset when clearing is disabled.
  always_ff @(posedge i_clk) begin
    if (clr_we_s) begin
      mem_r[clr_idx_r] <= '0;
    end else if (wr_s) begin
      for (int b = 0; b < NB; b++) begin
        if (be_s[b]) begin
          mem_r[idx_s][b*8 +: 8] <= wdat_s[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld_r <= 1'b0;
      s1_err_r <= 1'b0;
      s1_dat_r <= '0;
    end else begin
      s1_vld_r <= acc_s;
      s1_err_r <= acc_s & err_s;
      s1_dat_r <= acc_s ? rd_dat_s : '0;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_vld_r;
    logic                  s2_err_r;
    logic [DATA_WIDTH-1:0] s2_dat_r;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        s2_vld_r <= 1'b0;
        s2_err_r <= 1'b0;
        s2_dat_r <= '0;
      end else begin
        s2_vld_r <= s1_vld_r & i_cyc;
        s2_err_r <= s1_err_r;
        s2_dat_r <= s1_dat_r;
      end
    end

    assign rsp_vld_s = s2_vld_r;
    assign rsp_err_s = s2_err_r;
    assign rsp_dat_s = s2_dat_r;
  end else begin : g_lat1
    assign rsp_vld_s = s1_vld_r;
    assign rsp_err_s = s1_err_r;
    assign rsp_dat_s = s1_dat_r;
  end

  // Dropping i_cyc discards whatever is still travelling down the pipe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ack <= 1'b0;
      o_err <= 1'b0;
      o_dat <= '0;
    end else begin
      o_ack <= rsp_vld_s & i_cyc & ~rsp_err_s;
      o_err <= rsp_vld_s & i_cyc & rsp_err_s;
      o_dat <= (rsp_vld_s && i_cyc && !rsp_err_s) ? rsp_dat_s : '0;
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_wb_ram.sv
// Bench for leiwand_rv32_wb_ram: three configurations (32-bit clear/lat1, 32-bit based/lat2,
// 64-bit lat1) driven from a vector table plus hand sequences, checked by a response scoreboard.
module tb_leiwand_rv32_wb_ram;

  typedef struct {
    int          d;
    logic        w;
    logic [31:0] a;
    logic [63:0] wd;
    logic [3:0]  sz;
    logic        ee;
    logic [63:0] ed;
  } vec_t;

  typedef struct {
    logic        ee;
    logic [63:0] ed;
    int unsigned due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  cyc_v = 3'b000;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [63:0] dat = 64'h0;
  logic [3:0]  size = 4'd4;
  logic [2:0]  ack_v, err_v, stall_v, done_v;
  logic [31:0] rd_a, rd_b;
  logic [63:0] rd_c;
  int unsigned cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  vec_t vt[$];

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  leiwand_rv32_wb_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(16), .BASE_ADDR(32'h0),
                        .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_cyc(cyc_v[0]), .i_stb(stb), .i_we(we), .i_addr(addr),
    .i_dat(dat[31:0]), .i_dat_wr_size(size), .o_dat(rd_a), .o_ack(ack_v[0]), .o_err(err_v[0]),
    .o_stall(stall_v[0]), .o_init_done(done_v[0]));

  leiwand_rv32_wb_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(16), .BASE_ADDR(32'h100),
                        .READ_LATENCY(2), .CLEAR_ON_RESET(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_cyc(cyc_v[1]), .i_stb(stb), .i_we(we), .i_addr(addr),
    .i_dat(dat[31:0]), .i_dat_wr_size(size), .o_dat(rd_b), .o_ack(ack_v[1]), .o_err(err_v[1]),
    .o_stall(stall_v[1]), .o_init_done(done_v[1]));

  leiwand_rv32_wb_ram #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MEM_SIZE(16), .BASE_ADDR(32'h0),
                        .READ_LATENCY(1), .CLEAR_ON_RESET(0)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_cyc(cyc_v[2]), .i_stb(stb), .i_we(we), .i_addr(addr),
    .i_dat(dat), .i_dat_wr_size(size), .o_dat(rd_c), .o_ack(ack_v[2]), .o_err(err_v[2]),
    .o_stall(stall_v[2]), .o_init_done(done_v[2]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] rdat(input int d);
    case (d)
      0:       return {32'h0, rd_a};
      1:       return {32'h0, rd_b};
      default: return rd_c;
    endcase
  endfunction

  function automatic int unsigned lat(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void add(input int d, input logic w, input logic [31:0] a, input logic [63:0] wd,
                              input logic [3:0] sz, input logic ee, input logic [63:0] ed);
    vec_t v;
    v.d = d; v.w = w; v.a = a; v.wd = wd; v.sz = sz; v.ee = ee; v.ed = ed;
    vt.push_back(v);
  endfunction

  // Present one request for one cycle; the expected response is due lat(d) edges after acceptance.
  task automatic req(input int d, input logic w, input logic [31:0] a, input logic [63:0] wd,
                     input logic [3:0] sz, input logic ee, input logic [63:0] ed, input logic push);
    exp_t e;
    @(negedge clk); #1;
    cyc_v = 3'(1 << d);
    stb = 1'b1; we = w; addr = a; dat = wd; size = sz;
    if (push) begin
      e.ee = ee; e.ed = ed; e.due = cnt + 1 + lat(d);
      case (d)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic drain(input int d);
    @(negedge clk); #1;
    stb = 1'b0;
    for (int n = 0; n < 12 && qsize(d) != 0; n++) begin
      @(negedge clk); #2;
    end
    chk($sformatf("drain_d%0d", d), 64'(qsize(d)), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_ack_d%0d", tag, d), 64'(ack_v[d]), 64'd0);
      chk($sformatf("%s_err_d%0d", tag, d), 64'(err_v[d]), 64'd0);
      chk($sformatf("%s_dat_d%0d", tag, d), rdat(d), 64'd0);
      chk($sformatf("%s_stall_d%0d", tag, d), 64'(stall_v[d]), 64'd1);
      chk($sformatf("%s_done_d%0d", tag, d), 64'(done_v[d]), 64'd0);
    end
  endtask

  // Scoreboard: every ack/err must match the oldest outstanding request in cycle, kind and data.
  always @(negedge clk) begin : mon
    exp_t e;
    int   n;
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin
        if (ack_v[d] || err_v[d]) begin
          chk($sformatf("ack_err_excl_d%0d", d), 64'(ack_v[d] & err_v[d]), 64'd0);
          n = qsize(d);
          chk($sformatf("rsp_pending_d%0d", d), 64'(n > 0), 64'd1);
          if (n > 0) begin
            e = qpop(d);
            chk($sformatf("rsp_cycle_d%0d", d), 64'(cnt), 64'(e.due));
            chk($sformatf("rsp_err_d%0d", d), 64'(err_v[d]), 64'(e.ee));
            chk($sformatf("rsp_dat_d%0d", d), rdat(d), e.ed);
          end
        end else begin
          chk($sformatf("idle_dat_d%0d", d), rdat(d), 64'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int sa, sb, sc, n;
    logic [31:0] e3 [4];

    #2 rst = 1'b1;
    #2 chk_reset_outputs("por");
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    sa = 0; sb = 0; sc = 0;
    for (int i = 0; i < 21; i++) begin
      if (stall_v[0]) sa++;
      if (stall_v[1]) sb++;
      if (stall_v[2]) sc++;
      @(negedge clk);
    end
    chk("init_stall_cycles_a", 64'(sa), 64'd16);
    chk("init_stall_cycles_b", 64'(sb), 64'd1);
    chk("init_stall_cycles_c", 64'(sc), 64'd1);
    chk("init_done_all", 64'(done_v), 64'd7);

    add(0, 1'b0, 32'h0000_0000, 64'h0,                  4'd4, 1'b0, 64'h0);
    add(0, 1'b1, 32'h0000_0008, 64'hDEADBEEF,           4'd4, 1'b0, 64'h0);
    add(0, 1'b1, 32'h0000_000A, 64'hFFFFFF55,           4'd1, 1'b0, 64'h0);
    add(0, 1'b0, 32'h0000_0008, 64'h0,                  4'd4, 1'b0, 64'hDE55BEEF);
    add(0, 1'b1, 32'h0000_0003, 64'h1234,               4'd2, 1'b1, 64'h0);
    add(0, 1'b0, 32'h0000_0040, 64'h0,                  4'd4, 1'b1, 64'h0);
    add(0, 1'b1, 32'h0000_0000, 64'h12345678,           4'd3, 1'b1, 64'h0);
    add(0, 1'b1, 32'h0000_0000, 64'h12345678,           4'd8, 1'b1, 64'h0);
    add(0, 1'b0, 32'h0000_0000, 64'h0,                  4'd4, 1'b0, 64'h0);
    add(0, 1'b1, 32'h0000_0006, 64'h1234BEEF,           4'd2, 1'b0, 64'h0);
    add(0, 1'b0, 32'h0000_0004, 64'h0,                  4'd4, 1'b0, 64'hBEEF0000);
    add(0, 1'b0, 32'hFFFF_FFFC, 64'h0,                  4'd4, 1'b1, 64'h0);
    add(1, 1'b1, 32'h0000_0100, 64'h11111111,           4'd4, 1'b0, 64'h0);
    add(1, 1'b1, 32'h0000_0104, 64'h22222222,           4'd4, 1'b0, 64'h0);
    add(1, 1'b1, 32'h0000_0108, 64'h33333333,           4'd4, 1'b0, 64'h0);
    add(1, 1'b1, 32'h0000_010C, 64'h44444444,           4'd4, 1'b0, 64'h0);
    add(1, 1'b1, 32'h0000_010D, 64'hAB,                 4'd1, 1'b0, 64'h0);
    add(1, 1'b0, 32'h0000_00FC, 64'h0,                  4'd4, 1'b1, 64'h0);
    add(1, 1'b0, 32'h0000_0140, 64'h0,                  4'd4, 1'b1, 64'h0);
    add(1, 1'b0, 32'h0000_010C, 64'h0,                  4'd4, 1'b0, 64'h4444AB44);
    add(2, 1'b1, 32'h0000_0000, 64'h1122334455667788,   4'd8, 1'b0, 64'h0);
    add(2, 1'b1, 32'h0000_0004, 64'hAABBCCDD,           4'd4, 1'b0, 64'h0);
    add(2, 1'b0, 32'h0000_0000, 64'h0,                  4'd8, 1'b0, 64'hAABBCCDD55667788);
    add(2, 1'b1, 32'h0000_0002, 64'h9999,               4'd4, 1'b1, 64'h0);
    add(2, 1'b1, 32'h0000_0006, 64'hFFFFFFFFFFFFEEFF,   4'd2, 1'b0, 64'h0);
    add(2, 1'b0, 32'h0000_0000, 64'h0,                  4'd8, 1'b0, 64'hEEFFCCDD55667788);
    add(2, 1'b0, 32'h0000_0080, 64'h0,                  4'd8, 1'b1, 64'h0);
    add(2, 1'b1, 32'h0000_0008, 64'h1,                  4'd0, 1'b1, 64'h0);

    foreach (vt[i]) begin
      req(vt[i].d, vt[i].w, vt[i].a, vt[i].wd, vt[i].sz, vt[i].ee, vt[i].ed, 1'b1);
      drain(vt[i].d);
    end

    // Back-to-back write then read of the same word must return the new data.
    req(0, 1'b1, 32'h10, 64'hCAFEF00D, 4'd4, 1'b0, 64'h0, 1'b1);
    req(0, 1'b0, 32'h10, 64'h0,        4'd4, 1'b0, 64'hCAFEF00D, 1'b1);
    drain(0);

    // Four pipelined reads at latency 2: acks on consecutive cycles, in order.
    e3[0] = 32'h11111111; e3[1] = 32'h22222222; e3[2] = 32'h33333333; e3[3] = 32'h4444AB44;
    for (int i = 0; i < 4; i++) begin
      req(1, 1'b0, 32'h100 + 32'(4 * i), 64'h0, 4'd4, 1'b0, {32'h0, e3[i]}, 1'b1);
    end
    drain(1);

    // Read accepted, then the cycle is abandoned: no response may appear.
    req(1, 1'b0, 32'h100, 64'h0, 4'd4, 1'b0, 64'h0, 1'b0);
    @(negedge clk); #1;
    cyc_v = 3'b000; stb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      chk("drop_ack", 64'(ack_v[1]), 64'd0);
      chk("drop_err", 64'(err_v[1]), 64'd0);
    end

    // Reset asserted between edges while an ack is on the bus.
    req(0, 1'b0, 32'h8, 64'h0, 4'd4, 1'b0, 64'hDE55BEEF, 1'b1);
    @(negedge clk); #1;
    stb = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_ack", 64'(ack_v[0]), 64'd1);
    chk("pre_rst_dat", rdat(0), 64'hDE55BEEF);
    rst = 1'b1;
    cyc_v = 3'b000;
    #1 chk_reset_outputs("async_rst");
    q0.delete(); q1.delete(); q2.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (n < 40 && done_v != 3'b111) begin
      @(negedge clk);
      n++;
    end
    chk("reinit_done", 64'(done_v), 64'd7);

    req(0, 1'b0, 32'h8,   64'h0, 4'd4, 1'b0, 64'h0, 1'b1);
    drain(0);
    req(0, 1'b0, 32'h10,  64'h0, 4'd4, 1'b0, 64'h0, 1'b1);
    drain(0);
    req(1, 1'b0, 32'h10C, 64'h0, 4'd4, 1'b0, 64'h4444AB44, 1'b1);
    drain(1);
    req(2, 1'b0, 32'h0,   64'h0, 4'd8, 1'b0, 64'hEEFFCCDD55667788, 1'b1);
    drain(2);

    chk("q_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
